// File: rtl/fetch_decode_unit.sv
// ============================================================================
// fetch_decode_unit : credit-limited in-order fetch, DEPTH-entry instruction
//                     queue and combinational decode of the queue head.
// Revision: 1.0
// ============================================================================
`default_nettype none

module fetch_decode_unit #(
  parameter int              XLEN     = 32,
  parameter int              ILEN     = 32,
  parameter int              DEPTH    = 4,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  output logic            imem_req_valid_o,
  input  logic            imem_req_ready_i,
  output logic [XLEN-1:0] imem_req_addr_o,
  input  logic            imem_rsp_valid_i,
  input  logic [ILEN-1:0] imem_rsp_data_i,
  input  logic            redirect_valid_i,
  input  logic [XLEN-1:0] redirect_pc_i,
  output logic            dec_valid_o,
  input  logic            dec_ready_i,
  output logic [XLEN-1:0] dec_pc_o,
  output logic [6:0]      dec_opcode_o,
  output logic [9:0]      dec_func_o,
  output logic [XLEN-1:0] dec_valC_o,
  output logic [4:0]      dec_rs1_o,
  output logic [4:0]      dec_rs2_o,
  output logic [4:0]      dec_rd_o,
  output logic            dec_illegal_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  localparam logic [AW-1:0] C_PTR_ONE = AW'(1);
  localparam logic [CW-1:0] C_CNT_ONE = CW'(1);

  localparam logic [6:0] C_OP     = 7'b0110011;
  localparam logic [6:0] C_OP_IMM = 7'b0010011;
  localparam logic [6:0] C_LUI    = 7'b0110111;
  localparam logic [6:0] C_AUIPC  = 7'b0010111;
  localparam logic [6:0] C_JAL    = 7'b1101111;
  localparam logic [6:0] C_JALR   = 7'b1100111;
  localparam logic [6:0] C_BRANCH = 7'b1100011;
  localparam logic [6:0] C_LOAD   = 7'b0000011;
  localparam logic [6:0] C_STORE  = 7'b0100011;

  logic [XLEN-1:0] pc_q;
  logic [CW-1:0]   count_q;
  logic [CW-1:0]   inflight_q;
  logic [CW-1:0]   discard_q;
  logic [AW-1:0]   q_rd_q;
  logic [AW-1:0]   q_wr_q;
  logic [AW-1:0]   f_rd_q;
  logic [AW-1:0]   f_wr_q;

  logic [XLEN-1:0] q_pc_q   [DEPTH];
  logic [ILEN-1:0] q_inst_q [DEPTH];
  logic [XLEN-1:0] f_pc_q   [DEPTH];

  logic [CW:0]     w_occ;
  logic            w_credit;
  logic            w_req_fire;
  logic            w_rsp_keep;
  logic            w_pop;
  logic            w_unused;

  // Outstanding requests plus buffered words never exceed the queue size.
  assign w_occ            = {1'b0, inflight_q} + {1'b0, count_q};
  assign w_credit         = w_occ < (CW+1)'(DEPTH);
  assign imem_req_valid_o = rst_ni && !redirect_valid_i && w_credit;
  assign imem_req_addr_o  = pc_q;
  assign w_req_fire       = imem_req_valid_o && imem_req_ready_i;
  assign w_rsp_keep       = imem_rsp_valid_i && (discard_q == '0);
  assign dec_valid_o      = (count_q != '0);
  assign w_pop            = dec_valid_o && dec_ready_i;
  assign w_unused         = ^redirect_pc_i[1:0];

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      pc_q       <= RESET_PC;
      count_q    <= '0;
      inflight_q <= '0;
      discard_q  <= '0;
      q_rd_q     <= '0;
      q_wr_q     <= '0;
      f_rd_q     <= '0;
      f_wr_q     <= '0;
    end else if (redirect_valid_i) begin
      // Everything still outstanding after this edge belongs to the old path.
      pc_q       <= {redirect_pc_i[XLEN-1:2], 2'b00};
      count_q    <= '0;
      q_rd_q     <= '0;
      q_wr_q     <= '0;
      f_rd_q     <= '0;
      f_wr_q     <= '0;
      inflight_q <= inflight_q - CW'(imem_rsp_valid_i);
      discard_q  <= inflight_q - CW'(imem_rsp_valid_i);
    end else begin
      if (w_req_fire) begin
        pc_q   <= pc_q + XLEN'(4);
        f_wr_q <= f_wr_q + C_PTR_ONE;
      end
      inflight_q <= inflight_q + CW'(w_req_fire) - CW'(imem_rsp_valid_i);
      if (imem_rsp_valid_i) begin
        if (discard_q != '0) begin
          discard_q <= discard_q - C_CNT_ONE;
        end else begin
          f_rd_q <= f_rd_q + C_PTR_ONE;
          q_wr_q <= q_wr_q + C_PTR_ONE;
        end
      end
      if (w_pop) begin
        q_rd_q <= q_rd_q + C_PTR_ONE;
      end
      count_q <= count_q + CW'(w_rsp_keep) - CW'(w_pop);
    end
  end

  always_ff @(posedge clk_i) begin
    if (w_req_fire) begin
      f_pc_q[f_wr_q] <= pc_q;
    end
    if (!redirect_valid_i && w_rsp_keep) begin
      q_pc_q[q_wr_q]   <= f_pc_q[f_rd_q];
      q_inst_q[q_wr_q] <= imem_rsp_data_i;
    end
  end

  logic [ILEN-1:0] w_inst;
  logic [XLEN-1:0] w_valc;
  logic [4:0]      w_rs1;
  logic [4:0]      w_rs2;
  logic [4:0]      w_rd;
  logic            w_illegal;

  assign w_inst = q_inst_q[q_rd_q];

  always_comb begin
    w_valc    = '0;
    w_rs1     = '0;
    w_rs2     = '0;
    w_rd      = '0;
    w_illegal = 1'b0;
    case (w_inst[6:0])
      C_OP: begin
        w_rs1 = w_inst[19:15];
        w_rs2 = w_inst[24:20];
        w_rd  = w_inst[11:7];
      end
      C_OP_IMM, C_JALR, C_LOAD: begin
        w_rs1  = w_inst[19:15];
        w_rd   = w_inst[11:7];
        w_valc = {{(XLEN-11){w_inst[31]}}, w_inst[30:20]};
      end
      C_LUI, C_AUIPC: begin
        w_rd   = w_inst[11:7];
        w_valc = {{(XLEN-31){w_inst[31]}}, w_inst[30:12], 12'b0};
      end
      C_JAL: begin
        w_rd   = w_inst[11:7];
        w_valc = {{(XLEN-20){w_inst[31]}}, w_inst[19:12], w_inst[20],
                  w_inst[30:21], 1'b0};
      end
      C_BRANCH: begin
        w_rs1  = w_inst[19:15];
        w_rs2  = w_inst[24:20];
        w_valc = {{(XLEN-12){w_inst[31]}}, w_inst[7], w_inst[30:25],
                  w_inst[11:8], 1'b0};
      end
      C_STORE: begin
        w_rs1  = w_inst[19:15];
        w_rs2  = w_inst[24:20];
        w_valc = {{(XLEN-11){w_inst[31]}}, w_inst[30:25], w_inst[11:7]};
      end
      default: begin
        w_illegal = 1'b1;
      end
    endcase
  end

  assign dec_pc_o      = dec_valid_o ? q_pc_q[q_rd_q] : '0;
  assign dec_opcode_o  = dec_valid_o ? w_inst[6:0] : '0;
  assign dec_func_o    = dec_valid_o ? {w_inst[31:25], w_inst[14:12]} : '0;
  assign dec_valC_o    = dec_valid_o ? w_valc : '0;
  assign dec_rs1_o     = dec_valid_o ? w_rs1 : '0;
  assign dec_rs2_o     = dec_valid_o ? w_rs2 : '0;
  assign dec_rd_o      = dec_valid_o ? w_rd : '0;
  assign dec_illegal_o = dec_valid_o && w_illegal;

endmodule

`default_nettype wire
